// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
//   Assembles 9-byte command frames arriving from a UART receiver and presents
//   each one as a single command to a downstream AXI-Lite command master.
//   Frame byte order: opcode, addr[7:0..31:24], data[7:0..31:24] (both words
//   little-endian). Legal opcodes: 0x00 WRITE, 0x01 READ, 0x02 MOVE.
//
// Configuration macro:
//   UART_CMD_FRAMER_TIMEOUT_EN - when defined, a partial frame idle for
//   TIMEOUT_CYCLES cycles is discarded and err_timeout pulses. When undefined
//   the timeout counter is absent, err_timeout is tied low and the framer
//   waits indefinitely for the rest of a frame.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   rx_data[7:0] in   received byte
//   rx_valid     in   one-cycle strobe qualifying rx_data (no backpressure)
//   cmd_valid    out  assembled command presented
//   cmd_ready    in   downstream accepts the command
//   cmd_opcode   out  8-bit opcode
//   cmd_addr     out  32-bit address (source address for MOVE)
//   cmd_data     out  32-bit write data (destination address for MOVE)
//   busy         out  high whenever not IDLE
//   err_opcode   out  pulse: frame with illegal opcode dropped
//   err_overrun  out  pulse: byte dropped while a command is pending
//   err_timeout  out  pulse: partial frame aborted on inactivity
// ---------------------------------------------------------------------------
module uart_cmd_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_data,
    output logic        busy,
    output logic        err_opcode,
    output logic        err_overrun,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  idx_r;

    // A zero-cycle timeout is meaningless; reject it at elaboration.
    if (TIMEOUT_CYCLES < 32'd1) begin : g_bad_timeout
        $error("uart_cmd_framer: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
    logic [31:0] tcnt_r;
`else
    assign err_timeout = 1'b0;
`endif

    // Frame assembly FSM; all outputs are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= 8'h00;
            cmd_addr    <= 32'h0000_0000;
            cmd_data    <= 32'h0000_0000;
            busy        <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
            tcnt_r      <= 32'd0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // Error outputs are single-cycle pulses unless re-raised below.
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd_opcode <= rx_data;
                        idx_r      <= 4'd1;
                        state_r    <= ST_COLLECT;
                        busy       <= 1'b1;
                    end else begin
                        idx_r      <= 4'd0;
                    end
                end

                ST_COLLECT: begin
                    if (rx_valid) begin
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
                        tcnt_r <= 32'd0;
`endif
                        case (idx_r)
                            4'd1:    cmd_addr[7:0]   <= rx_data;
                            4'd2:    cmd_addr[15:8]  <= rx_data;
                            4'd3:    cmd_addr[23:16] <= rx_data;
                            4'd4:    cmd_addr[31:24] <= rx_data;
                            4'd5:    cmd_data[7:0]   <= rx_data;
                            4'd6:    cmd_data[15:8]  <= rx_data;
                            4'd7:    cmd_data[23:16] <= rx_data;
                            4'd8:    cmd_data[31:24] <= rx_data;
                            default: cmd_data        <= cmd_data;
                        endcase
                        if (idx_r == 4'd8) begin
                            idx_r <= 4'd0;
                            // The opcode was captured first, so it can be
                            // validated as the last byte lands.
                            if (cmd_opcode <= 8'h02) begin
                                state_r   <= ST_ISSUE;
                                cmd_valid <= 1'b1;
                            end else begin
                                state_r    <= ST_IDLE;
                                busy       <= 1'b0;
                                err_opcode <= 1'b1;
                            end
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end else begin
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
                        if (tcnt_r == TIMEOUT_LAST) begin
                            state_r     <= ST_IDLE;
                            busy        <= 1'b0;
                            idx_r       <= 4'd0;
                            tcnt_r      <= 32'd0;
                            err_timeout <= 1'b1;
                        end else if (tcnt_r != 32'hFFFF_FFFF) begin
                            tcnt_r <= tcnt_r + 32'd1;
                        end else begin
                            tcnt_r <= tcnt_r;
                        end
`else
                        idx_r <= idx_r;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        // A byte landing on the handshake cycle opens the
                        // next frame instead of being lost.
                        if (rx_valid) begin
                            cmd_opcode <= rx_data;
                            idx_r      <= 4'd1;
                            state_r    <= ST_COLLECT;
                        end else begin
                            state_r    <= ST_IDLE;
                            busy       <= 1'b0;
                        end
                    end else if (rx_valid) begin
                        err_overrun <= 1'b1;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= 4'd0;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
module tb_uart_cmd_framer;

    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        busy;
    logic        err_opcode;
    logic        err_overrun;
    logic        err_timeout;

    int vectors;
    int miscompares;
    int n_multi_err;

    uart_cmd_framer #(.TIMEOUT_CYCLES(100)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles where more than one error pulse is high at once.
    always @(posedge clock) begin
        if ((32'(err_opcode) + 32'(err_overrun) + 32'(err_timeout)) > 32'd1)
            n_multi_err <= n_multi_err + 1;
    end

    // Drive one byte for one cycle; called and returning at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Send bytes first..last of a frame packed with byte 0 in bits [7:0].
    task automatic send_range(input logic [71:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(f[8*i +: 8]);
    endtask

    task automatic test_reset;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
        #2;
        vectors++;
        if ({cmd_valid, busy, err_opcode, err_overrun, err_timeout, cmd_opcode, cmd_addr, cmd_data} !== 77'd0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b busy=%b op=%h addr=%h data=%h errs=%b%b%b, want all 0",
                     cmd_valid, busy, cmd_opcode, cmd_addr, cmd_data, err_opcode, err_overrun, err_timeout);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_write;
        logic [71:0] f;
        f = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        cmd_ready = 1'b1;
        send_range(f, 0, 7);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_partial: valid=%b busy=%b, want 0 1", cmd_valid, busy);
        end
        send_range(f, 8, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h00 || cmd_addr !== 32'h0001_0000 || cmd_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_cmd: valid=%b op=%h addr=%h data=%h, want 1 00 00010000 deadbeef",
                     cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        @(negedge clock);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_pulse_end: valid=%b busy=%b, want 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_move;
        logic [71:0] f;
        f = {8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
        cmd_ready = 1'b0;
        send_range(f, 0, 8);
        for (int i = 0; i < 50; i++) begin
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h02 || cmd_addr !== 32'h0002_0000 || cmd_data !== 32'h0002_0010) begin
                miscompares++;
                $display("FAIL move_hold[%0d]: valid=%b op=%h addr=%h data=%h, want 1 02 00020000 00020010",
                         i, cmd_valid, cmd_opcode, cmd_addr, cmd_data);
            end
            @(negedge clock);
        end
        cmd_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL move_release: valid=%b busy=%b, want 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_illegal_opcode;
        logic [71:0] bad;
        logic [71:0] rd;
        bad = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h07};
        rd  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h40, 8'h00, 8'h01};
        cmd_ready = 1'b1;
        send_range(bad, 0, 8);
        vectors++;
        if (err_opcode !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_drop: err_opcode=%b valid=%b busy=%b, want 1 0 0", err_opcode, cmd_valid, busy);
        end
        @(negedge clock);
        vectors++;
        if (err_opcode !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_pulse_width: err_opcode=%b valid=%b, want 0 0", err_opcode, cmd_valid);
        end
        send_range(rd, 0, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_addr !== 32'h0001_4000) begin
            miscompares++;
            $display("FAIL illegal_then_read: valid=%b op=%h addr=%h, want 1 01 00014000", cmd_valid, cmd_opcode, cmd_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_timeout;
        logic [71:0] head;
        logic [71:0] wr;
        int pulses;
        int pulse_at;
        head = {8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
        wr   = {8'h01, 8'h02, 8'h03, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        cmd_ready = 1'b1;
        pulses = 0;
        pulse_at = -1;
        send_range(head, 0, 3);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (err_timeout === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
        vectors++;
        if (pulses != 1 || pulse_at != 100 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: pulses=%0d at=%0d busy=%b, want 1 at 100 busy 0", pulses, pulse_at, busy);
        end
`else
        vectors++;
        if (pulses != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout_wait: pulses=%0d busy=%b, want 0 1", pulses, busy);
        end
        send_range(head, 4, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h02 || cmd_addr !== 32'h0002_0000 || cmd_data !== 32'h0002_0010) begin
            miscompares++;
            $display("FAIL no_timeout_resume: valid=%b op=%h addr=%h data=%h, want 1 02 00020000 00020010",
                     cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        @(negedge clock);
`endif
        send_range(wr, 0, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h00 || cmd_addr !== 32'h1234_5678 || cmd_data !== 32'h0102_0304) begin
            miscompares++;
            $display("FAIL timeout_next_frame: valid=%b op=%h addr=%h data=%h, want 1 00 12345678 01020304",
                     cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        @(negedge clock);
    endtask

    task automatic test_overrun;
        logic [71:0] rd;
        rd = {8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01};
        cmd_ready = 1'b0;
        send_range(rd, 0, 8);
        send_byte(8'h5A);
        vectors++;
        if (err_overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 ||
            cmd_addr !== 32'h0000_0010 || cmd_data !== 32'hDDCC_BBAA) begin
            miscompares++;
            $display("FAIL overrun: err=%b valid=%b op=%h addr=%h data=%h, want 1 1 01 00000010 ddccbbaa",
                     err_overrun, cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        @(negedge clock);
        vectors++;
        if (err_overrun !== 1'b0 || cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_pulse_width: err=%b valid=%b, want 0 1", err_overrun, cmd_valid);
        end
        cmd_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_release: valid=%b busy=%b, want 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [71:0] a;
        logic [71:0] b;
        a = {8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
        b = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01};
        cmd_ready = 1'b0;
        send_range(a, 0, 8);
        cmd_ready = 1'b1;
        send_range(b, 0, 0);
        vectors++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || err_overrun !== 1'b0 || cmd_opcode !== 8'h01) begin
            miscompares++;
            $display("FAIL b2b_handshake_byte: valid=%b busy=%b ovr=%b op=%h, want 0 1 0 01",
                     cmd_valid, busy, err_overrun, cmd_opcode);
        end
        send_range(b, 1, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_addr !== 32'h0002_0000) begin
            miscompares++;
            $display("FAIL b2b_second: valid=%b op=%h addr=%h, want 1 01 00020000", cmd_valid, cmd_opcode, cmd_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_frame;
        logic [71:0] f;
        logic [71:0] g;
        f = {8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        g = {8'h00, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        cmd_ready = 1'b1;
        send_range(f, 0, 4);
        reset = 1'b0;
        #1;
        vectors++;
        if ({cmd_valid, busy, err_opcode, err_overrun, err_timeout, cmd_opcode, cmd_addr, cmd_data} !== 77'd0) begin
            miscompares++;
            $display("FAIL reset_async: valid=%b busy=%b op=%h addr=%h data=%h, want all 0",
                     cmd_valid, busy, cmd_opcode, cmd_addr, cmd_data);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        send_range(g, 0, 7);
        vectors++;
        if (cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_stale_cmd: valid=%b, want 0", cmd_valid);
        end
        send_range(g, 8, 8);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h00 || cmd_addr !== 32'h0000_0001 || cmd_data !== 32'h0000_ABCD) begin
            miscompares++;
            $display("FAIL reset_next_frame: valid=%b op=%h addr=%h data=%h, want 1 00 00000001 0000abcd",
                     cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        @(negedge clock);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n_multi_err = 0;
        test_reset();
        test_write();
        test_move();
        test_illegal_opcode();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        @(negedge clock);
        vectors++;
        if (n_multi_err != 0) begin
            miscompares++;
            $display("FAIL single_error_pulse: %0d cycles with simultaneous errors, want 0", n_multi_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
